// File: rtl/jk_ff_driver.sv
// Drives J/K excitation onto an external JK flip-flop so that it reaches a requested
// target state, then checks the fed-back Q and keeps a sticky error flag and saturating count.
module jk_ff_driver (
    input  logic       Clk,
    input  logic       rst,
    input  logic       d_valid,
    input  logic       d,
    input  logic       mode,
    input  logic       q_fb,
    input  logic       err_clr,
    output logic       d_ready,
    output logic       J,
    output logic       K,
    output logic       exp_q,
    output logic       mismatch,
    output logic [7:0] err_cnt,
    output logic [1:0] state_dbg
);

    // Handshake: a request transfers on a rising Clk edge where d_valid and d_ready
    // are both high; d_ready is high only in IDLE, so nothing is taken during DRIVE/CHECK.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       exp_st_q, exp_st_d;
    logic       d_lat_q, d_lat_d;
    logic       mis_q, mis_d;
    logic [7:0] cnt_q, cnt_d;
    logic       bad;

    always_comb begin
        state_d  = state_q;
        j_d      = 1'b0;
        k_d      = 1'b0;
        exp_st_d = exp_st_q;
        d_lat_d  = d_lat_q;
        mis_d    = mis_q;
        cnt_d    = cnt_q;
        bad      = (state_q == CHECK) && (q_fb != exp_st_q);

        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    state_d = DRIVE;
                    d_lat_d = d;
                    // Excitation is computed at accept so J/K are valid for the whole DRIVE cycle.
                    if (mode) begin
                        j_d = (d != exp_st_q);
                        k_d = (d != exp_st_q);
                    end else begin
                        j_d = d;
                        k_d = ~d;
                    end
                end
            end
            DRIVE: begin
                exp_st_d = d_lat_q;
                state_d  = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (bad) exp_st_d = q_fb;
            end
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            mis_d = 1'b0;
            cnt_d = 8'd0;
        end
        // A mismatch on the same edge as a clear wins and counts as the first new error.
        if (bad) begin
            mis_d = 1'b1;
            if (err_clr)            cnt_d = 8'd1;
            else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            else                    cnt_d = cnt_q;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            exp_st_q <= 1'b0;
            d_lat_q  <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            k_q      <= k_d;
            exp_st_q <= exp_st_d;
            d_lat_q  <= d_lat_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    assign d_ready   = (state_q == IDLE);
    assign J         = j_q;
    assign K         = k_q;
    assign exp_q     = exp_st_q;
    assign mismatch  = mis_q;
    assign err_cnt   = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench for jk_ff_driver: a real JK flip-flop model closes the loop, and a
// transaction-level reference tracks the expected state, error flag and count.
module tb_jk_ff_driver;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_valid = 1'b0;
    logic       d = 1'b0;
    logic       mode = 1'b0;
    logic       q_fb;
    logic       err_clr = 1'b0;
    logic       d_ready, J, K, exp_q, mismatch;
    logic [7:0] err_cnt;
    logic [1:0] state_dbg;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int cyc = 0;

    logic ff_q;
    logic force_en = 1'b0;
    logic force_val = 1'b0;

    // Reference state, kept per transaction rather than per cycle.
    logic       m_exp;
    logic       m_mis;
    int         m_cnt;
    logic [1:0] jk_exp_q[$];

    jk_ff_driver dut (
        .Clk(Clk), .rst(rst), .d_valid(d_valid), .d(d), .mode(mode),
        .q_fb(q_fb), .err_clr(err_clr), .d_ready(d_ready), .J(J), .K(K),
        .exp_q(exp_q), .mismatch(mismatch), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // The flip-flop being driven; q_fb can be overridden to emulate a faulty device.
    always @(posedge Clk or negedge rst) begin
        if (!rst) ff_q <= 1'b0;
        else begin
            case ({J, K})
                2'b10:   ff_q <= 1'b1;
                2'b01:   ff_q <= 1'b0;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_fb = force_en ? force_val : ff_q;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_exp = 1'b0;
        m_mis = 1'b0;
        m_cnt = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        tick();
    endtask

    // One request from offer to return to IDLE. td/tm: request; fe/fv: feedback override
    // during CHECK; clr: err_clr on the CHECK edge; hold: leave d_valid high afterwards.
    task automatic do_txn(input logic td, input logic tm, input logic fe, input logic fv,
                          input logic clr, input logic hold, output int acc_cyc);
        int   w;
        logic qv;
        logic [1:0] jk;
        d_valid = 1'b1;
        d = td;
        mode = tm;
        w = 0;
        while (!d_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_wait", {7'd0, d_ready}, 8'd1);
        if (tm) jk_exp_q.push_back((td != m_exp) ? 2'b11 : 2'b00);
        else    jk_exp_q.push_back(td ? 2'b10 : 2'b01);
        acc_cyc = cyc;
        tick();
        d = 1'($urandom);
        mode = 1'($urandom);
        jk = jk_exp_q.pop_front();
        check("drive_jk", {6'd0, J, K}, {6'd0, jk});
        check("drive_ready", {7'd0, d_ready}, 8'd0);
        force_en = fe;
        force_val = fv;
        tick();
        check("check_jk", {6'd0, J, K}, 8'd0);
        check("check_exp", {7'd0, exp_q}, {7'd0, td});
        check("check_ready", {7'd0, d_ready}, 8'd0);
        err_clr = clr;
        tick();
        err_clr = 1'b0;
        qv = fe ? fv : td;
        if (clr) begin
            m_cnt = 0;
            m_mis = 1'b0;
        end
        if (qv != td) begin
            m_mis = 1'b1;
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
        m_exp = qv;
        check("idle_exp", {7'd0, exp_q}, {7'd0, m_exp});
        check("idle_mis", {7'd0, mismatch}, {7'd0, m_mis});
        check("idle_cnt", err_cnt, 8'(m_cnt));
        check("idle_ready", {7'd0, d_ready}, 8'd1);
        check("idle_latency", 8'(cyc - acc_cyc), 8'd3);
        force_en = 1'b0;
        d_valid = hold;
    endtask

    initial begin
        int a0, a1, gap;
        logic td;
        model_reset();
        tick();
        check("rst_ready", {7'd0, d_ready}, 8'd1);
        check("rst_jk", {6'd0, J, K}, 8'd0);
        check("rst_exp", {7'd0, exp_q}, 8'd0);
        rst = 1'b1;
        tick();
        check("rel_mis", {7'd0, mismatch}, 8'd0);
        check("rel_cnt", err_cnt, 8'd0);

        // Set/reset style to 1, then hold and toggle in minimal style.
        d_valid = 1'b1; d = 1'b1; mode = 1'b0;
        tick();
        check("basic_j", {7'd0, J}, 8'd1);
        check("basic_k", {7'd0, K}, 8'd0);
        d_valid = 1'b0;
        tick();
        check("basic_exp", {7'd0, exp_q}, 8'd1);
        check("basic_qfb", {7'd0, q_fb}, 8'd1);
        check("basic_ready_lo", {7'd0, d_ready}, 8'd0);
        tick();
        check("basic_mis", {7'd0, mismatch}, 8'd0);
        check("basic_ready", {7'd0, d_ready}, 8'd1);
        m_exp = 1'b1;
        do_txn(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a0);
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a0);
        check("toggle_exp0", {7'd0, exp_q}, 8'd0);

        // Random requests with idle gaps and junk on d/mode while not offered.
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                d = 1'($urandom);
                mode = 1'($urandom);
                tick();
            end
            do_txn(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, a0);
        end

        // d_valid held high with alternating d: one accept every 3 cycles.
        td = 1'b0;
        do_txn(td, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a0);
        for (int i = 0; i < 10; i++) begin
            td = ~td;
            do_txn(td, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a1);
            check("b2b_spacing", 8'(a1 - a0), 8'd3);
            a0 = a1;
        end
        d_valid = 1'b0;
        tick();

        // Reset in the middle of a DRIVE cycle.
        apply_reset();
        d_valid = 1'b1; d = 1'b1; mode = 1'b0;
        tick();
        d_valid = 1'b0;
        check("abort_j_before", {7'd0, J}, 8'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_jk", {6'd0, J, K}, 8'd0);
        check("abort_exp", {7'd0, exp_q}, 8'd0);
        check("abort_cnt", err_cnt, 8'd0);
        #2 rst = 1'b1;
        model_reset();
        tick();
        check("abort_ready", {7'd0, d_ready}, 8'd1);
        check("abort_cnt2", err_cnt, 8'd0);

        // Feedback stuck at 0: count climbs and saturates.
        for (int i = 0; i < 300; i++)
            do_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a0);
        check("sat_cnt", err_cnt, 8'd255);
        check("sat_mis", {7'd0, mismatch}, 8'd1);
        check("sat_exp", {7'd0, exp_q}, 8'd0);

        // Clear coincident with a mismatch, then a plain clear in IDLE.
        apply_reset();
        for (int i = 0; i < 5; i++)
            do_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a0);
        check("pre_clr_cnt", err_cnt, 8'd5);
        do_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a0);
        check("clr_hit_cnt", err_cnt, 8'd1);
        check("clr_hit_mis", {7'd0, mismatch}, 8'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_idle_cnt", err_cnt, 8'd0);
        check("clr_idle_mis", {7'd0, mismatch}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
